uart_config_sequencer: RTL and testbench

//  Master-side sequencer that pushes a new frame format (data width, stop bits, parity) to the remote UART.
//  - Sends one configuration packet per setting, then the END_CONFIGURATION packet.
//  - Waits for ACKN_PKT (8'hFF) after each packet; retries on timeout or a wrong byte.
//  - Sits between the main control FSM (start/done) and the TX/RX byte paths of the UART.

---
 rtl/uart_config_sequencer.sv | 169 ++++++++++++++++
 tb/tb_uart_config_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_config_sequencer.sv
// uart_config_sequencer
//   Master-side sequencer that pushes a new frame format (data width, stop
//   bits, parity) to the remote UART. It sends one packet per setting and
//   then END_CONFIGURATION. After each packet it waits for ACKN_PKT and
//   resends the packet on a timeout or on a wrong reply byte.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   start_i, config_i  start request; config_i is {data_width, stop_bits, parity_mode}
//   tx_data_o/tx_req_o/tx_ack_i   packet byte handshake towards the TX path
//   rx_data_i/rx_valid_i          reply bytes from the RX path
//   busy_o, done_o, fail_o        sequence status (done/fail are one-cycle pulses)
//   active_config_o               configuration currently in force on the link
//
// State table
//   IDLE     | waiting for start_i
//   CHECK    | reject a reserved stop-bit setting before anything is sent
//   SEND     | present the current packet until the TX path accepts it
//   WAIT_ACK | wait for ACKN_PKT; a wrong byte or a timeout triggers a resend
//   DONE     | every packet acknowledged; commit the new configuration
//   FAIL     | reserved setting or retries exhausted; keep the old configuration
module uart_config_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [5:0] config_i,
  output logic [7:0] tx_data_o,
  output logic       tx_req_o,
  input  logic       tx_ack_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [5:0] active_config_o
);

  typedef struct packed {
    logic [1:0] data_width;
    logic [1:0] stop_bits;
    logic [1:0] parity_mode;
  } uart_config_s;

  typedef enum logic [2:0] {
    IDLE, CHECK, SEND, WAIT_ACK, DONE, FAIL
  } state_e;

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [5:0]         STD_CONFIG        = 6'b11_11_01;
  localparam logic [1:0]         SB_RESERVED       = 2'b10;
  localparam logic [1:0]         DATA_WIDTH_ID     = 2'b01;
  localparam logic [1:0]         STOP_BITS_ID      = 2'b10;
  localparam logic [1:0]         PARITY_MODE_ID    = 2'b11;
  localparam logic [7:0]         END_CONFIGURATION = 8'h00;
  localparam logic [7:0]         ACKN_PKT          = 8'hFF;
  localparam logic [1:0]         LAST_STEP         = 2'd3;
  localparam logic [TIMER_W-1:0] TIMER_LAST        = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_SAT         = {TIMER_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_LIMIT       = RETRY_W'(MAX_RETRY);

  function automatic logic [7:0] assemble_packet(input logic [1:0] id, input logic [1:0] opt);
    return {4'b0000, opt, id};
  endfunction

  state_e             state_q, state_d;
  uart_config_s       cfg_q, cfg_d;
  logic [1:0]         step_q, step_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [5:0]         active_q, active_d;
  logic [7:0]         packet;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cfg_q    <= STD_CONFIG;
      step_q   <= '0;
      retry_q  <= '0;
      timer_q  <= '0;
      active_q <= STD_CONFIG;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      step_q   <= step_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    step_d   = step_q;
    retry_d  = retry_q;
    timer_d  = timer_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cfg_d   = uart_config_s'(config_i);
          step_d  = '0;
          retry_d = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = (cfg_q.stop_bits == SB_RESERVED) ? FAIL : SEND;
      end
      SEND: begin
        if (tx_ack_i) begin
          timer_d = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (timer_q != TIMER_SAT) timer_d = timer_q + 1'b1;
        // A good ack takes priority over a timeout landing in the same cycle.
        if (rx_valid_i && (rx_data_i == ACKN_PKT)) begin
          if (step_q == LAST_STEP) begin
            state_d = DONE;
          end else begin
            step_d  = step_q + 2'd1;
            retry_d = '0;
            state_d = SEND;
          end
        end else if (rx_valid_i || (timer_q == TIMER_LAST)) begin
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 1'b1;
            state_d = SEND;
          end else begin
            state_d = FAIL;
          end
        end
      end
      DONE: begin
        active_d = cfg_q;
        state_d  = IDLE;
      end
      FAIL: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    packet = END_CONFIGURATION;
    case (step_q)
      2'd0:    packet = assemble_packet(DATA_WIDTH_ID, cfg_q.data_width);
      2'd1:    packet = assemble_packet(STOP_BITS_ID, cfg_q.stop_bits);
      2'd2:    packet = assemble_packet(PARITY_MODE_ID, cfg_q.parity_mode);
      default: packet = END_CONFIGURATION;
    endcase
  end

  assign tx_req_o        = (state_q == SEND);
  assign tx_data_o       = (state_q == SEND) ? packet : 8'h00;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);
  assign fail_o          = (state_q == FAIL);
  assign active_config_o = active_q;

endmodule

// File: tb/tb_uart_config_sequencer.sv
// Bench for uart_config_sequencer: expected TX bytes come from a queue filled
// from the configuration by arithmetic; a negedge compare process checks the
// DUT against it every cycle, and directed scenarios add literal checks.
module tb_uart_config_sequencer;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned RETRIES = 3;
  localparam logic [5:0]  STD     = 6'b11_11_01;
  localparam logic [5:0]  CFG_A   = 6'b10_00_11;
  localparam logic [5:0]  CFG_B   = 6'b01_11_00;

  logic       clk, rst, start_i, tx_ack_i, rx_valid_i;
  logic [5:0] config_i;
  logic [7:0] rx_data_i;
  logic [7:0] tx_data_o;
  logic       tx_req_o, busy_o, done_o, fail_o;
  logic [5:0] active_config_o;

  uart_config_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRY(RETRIES)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .config_i(config_i),
    .tx_data_o(tx_data_o), .tx_req_o(tx_req_o), .tx_ack_i(tx_ack_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .busy_o(busy_o),
    .done_o(done_o), .fail_o(fail_o), .active_config_o(active_config_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] hs_log[$];
  int         hs_cyc[$];
  logic [5:0] m_active = STD;
  logic [5:0] m_next_active = STD;
  int exp_done = 0, exp_fail = 0;
  int done_count = 0, fail_count = 0, hs_count = 0;
  int cyc = 0, start_cyc = 0, fail_cyc = 0;
  logic       prev_hold = 1'b0, prev_done = 1'b0, prev_fail = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       req_d1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet for a step: id = step+1, option = the step-th 2-bit field from the top.
  function automatic logic [7:0] pkt(input logic [5:0] c, input int step);
    int opt;
    if (step == 3) return 8'h00;
    opt = (int'(c) >> (4 - 2 * step)) & 3;
    return 8'(opt * 4 + step + 1);
  endfunction

  task automatic push_cfg(input logic [5:0] c);
    for (int s = 0; s < 4; s++) exp_q.push_back(pkt(c, s));
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // TX path model: accepts a byte on the second cycle of its request.
  initial begin
    tx_ack_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ack_i = tx_req_o && req_d1 && !tx_ack_i;
      req_d1   = tx_req_o && !tx_ack_i;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("active_config", 32'(active_config_o), 32'(m_active));
      if (exp_q.size() == 0) check("tx_req_idle", 32'(tx_req_o), 32'd0);
      else if (tx_req_o) begin
        check("tx_data", 32'(tx_data_o), 32'(exp_q[0]));
        if (tx_ack_i) begin
          hs_log.push_back(tx_data_o);
          hs_cyc.push_back(cyc);
          void'(exp_q.pop_front());
          hs_count++;
        end
      end
      if (tx_req_o && prev_hold) check("tx_stable", 32'(tx_data_o), 32'(prev_data));
      prev_hold = tx_req_o && !tx_ack_i;
      prev_data = tx_data_o;
      if (done_o) begin
        check("done_expected", 32'(exp_done), 32'd1);
        if (exp_done > 0) exp_done--;
        m_active = m_next_active;
        done_count++;
      end
      if (fail_o) begin
        check("fail_expected", 32'(exp_fail), 32'd1);
        if (exp_fail > 0) exp_fail--;
        fail_cyc = cyc;
        fail_count++;
      end
      check("pulse_width", 32'((done_o && prev_done) || (fail_o && prev_fail)), 32'd0);
      prev_done = done_o;
      prev_fail = fail_o;
      if (start_i && !busy_o) start_cyc = cyc;
    end
  end

  task automatic do_start(input logic [5:0] c);
    @(posedge clk);
    #1 start_i = 1'b1;
    config_i = c;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_hs();
    int s = hs_count;
    int n = 0;
    while (hs_count == s && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("hs_wait", 32'(hs_count != s), 32'd1);
  endtask

  task automatic rx_after(input logic [7:0] b, input int d);
    repeat (d) @(posedge clk);
    #1 rx_valid_i = 1'b1;
    rx_data_i = b;
    @(posedge clk);
    #1 rx_valid_i = 1'b0;
    rx_data_i = 8'h00;
  endtask

  task automatic wait_done();
    int s = done_count;
    int n = 0;
    while (done_count == s && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1 check("done_wait", 32'(done_count != s), 32'd1);
  endtask

  task automatic wait_fail();
    int s = fail_count;
    int n = 0;
    while (fail_count == s && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1 check("fail_wait", 32'(fail_count != s), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    m_active  = STD;
    exp_done  = 0;
    exp_fail  = 0;
    prev_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_log(input string name, input int base, input logic [31:0] packed4);
    logic [31:0] p = packed4;
    for (int i = 0; i < 4; i++)
      check(name, 32'(hs_log[base + i]), 32'(p[31 - 8 * i -: 8]));
  endtask

  initial begin
    int base;
    rst = 1'b1; start_i = 1'b0; config_i = 6'h00;
    rx_valid_i = 1'b0; rx_data_i = 8'h00;
    #2;
    check("rst_tx_data", 32'(tx_data_o), 32'd0);
    check("rst_tx_req", 32'(tx_req_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done_fail", 32'({done_o, fail_o}), 32'd0);
    check("rst_active", 32'(active_config_o), 32'h3D);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1 nominal sequence
    base = hs_log.size();
    push_cfg(CFG_A); exp_done = 1; m_next_active = CFG_A;
    do_start(CFG_A);
    check("busy_after_start", 32'(busy_o), 32'd1);
    for (int s = 0; s < 4; s++) begin wait_hs(); rx_after(8'hFF, 0); end
    wait_done();
    check_log("nominal_bytes", base, 32'h09_02_0F_00);
    check("nominal_active", 32'(active_config_o), 32'h23);
    check("nominal_busy", 32'(busy_o), 32'd0);

    // 2 timeout on the stop-bits packet
    do_reset();
    base = hs_log.size();
    exp_q.push_back(8'h09);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h02);
    exp_fail = 1;
    do_start(CFG_A);
    wait_hs(); rx_after(8'hFF, 0);
    for (int i = 0; i < 4; i++) wait_hs();
    wait_fail();
    for (int i = 1; i < 4; i++)
      check("resend_interval", 32'(hs_cyc[base + 1 + i] - hs_cyc[base + i]), 32'd18);
    check("timeout_sends", 32'(hs_log.size() - base), 32'd5);
    check("timeout_active", 32'(active_config_o), 32'h3D);
    check("timeout_queue", 32'(exp_q.size()), 32'd0);

    // 3 nack then ack
    base = hs_log.size();
    exp_q.push_back(8'h09); push_cfg(CFG_A);
    exp_done = 1; m_next_active = CFG_A;
    do_start(CFG_A);
    wait_hs(); rx_after(8'h55, 0);
    for (int s = 0; s < 4; s++) begin wait_hs(); rx_after(8'hFF, 0); end
    wait_done();
    check("nack_resend0", 32'(hs_log[base]), 32'h09);
    check("nack_resend1", 32'(hs_log[base + 1]), 32'h09);
    check("nack_active", 32'(active_config_o), 32'h23);

    // 4 reserved stop bits
    base = hs_log.size();
    exp_fail = 1;
    do_start(6'b11_10_01);
    wait_fail();
    check("reserved_latency", 32'(fail_cyc - start_cyc), 32'd2);
    check("reserved_no_tx", 32'(hs_log.size() - base), 32'd0);
    check("reserved_active", 32'(active_config_o), 32'h23);

    // 5 collision start ignored; ack coincident with timeout
    base = hs_log.size();
    push_cfg(CFG_A); exp_done = 1; m_next_active = CFG_A;
    do_start(CFG_A);
    wait_hs(); rx_after(8'hFF, TIMEOUT - 1);
    wait_hs();
    @(posedge clk);
    #1 start_i = 1'b1; config_i = CFG_B;
    check("busy_collision", 32'(busy_o), 32'd1);
    @(posedge clk);
    #1 start_i = 1'b0;
    rx_after(8'hFF, 2);
    for (int s = 0; s < 2; s++) begin wait_hs(); rx_after(8'hFF, 0); end
    wait_done();
    check_log("collision_bytes", base, 32'h09_02_0F_00);
    check("collision_active", 32'(active_config_o), 32'h23);

    // 6 reset during step 2 wait, then a full rerun
    push_cfg(CFG_A);
    do_start(CFG_A);
    for (int s = 0; s < 2; s++) begin wait_hs(); rx_after(8'hFF, 0); end
    wait_hs();
    #1 rst = 1'b1;
    exp_q.delete(); m_active = STD; prev_hold = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_outputs", 32'({tx_req_o, busy_o, done_o, fail_o}), 32'd0);
    check("midrst_tx_data", 32'(tx_data_o), 32'd0);
    check("midrst_active", 32'(active_config_o), 32'h3D);
    @(posedge clk);
    #1 rst = 1'b0;
    base = hs_log.size();
    push_cfg(CFG_B); exp_done = 1; m_next_active = CFG_B;
    do_start(CFG_B);
    for (int s = 0; s < 4; s++) begin wait_hs(); rx_after(8'hFF, 0); end
    wait_done();
    check_log("rerun_bytes", base, 32'h05_0E_03_00);
    check("rerun_active", 32'(active_config_o), 32'h1C);
    check("final_pending", 32'(exp_done + exp_fail + exp_q.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
